// File: rtl/cpu_configuration.sv
// Shared configuration for the issue scoreboard: controller state encoding,
// register-address width and architectural register count.
package cpu_configuration;

  // Register-address width used by every decode/write-back port.
  localparam int unsigned RegAdrW = 5;

  // Architectural register count; register 0 is hard-wired zero.
  localparam int unsigned NREG = 32;

  // Widest supported drain down-counter (FLUSH_CYCLES is 1..15).
  localparam int unsigned DrainW = 4;

  typedef enum logic [0:0] {
    Run   = 1'b0,
    Drain = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_counter.sv
// Saturating up/down pending-write counter for one architectural register.
// Clear wins over everything; simultaneous inc and dec leave the count alone.
module sb_counter #(
  parameter int unsigned CntW = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic inc_i,
  input  logic dec_i,
  input  logic clr_i,
  output logic max_o,
  output logic zero_o
);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign max_o  = (cnt_q == {CntW{1'b1}});
  assign zero_o = (cnt_q == '0);

  // Next-count selection with saturation at both ends.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && !dec_i && !max_o) begin
      cnt_d = cnt_q + 1'b1;
    end else if (dec_i && !inc_i && !zero_o) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Hazard-aware issue controller between decode and register read.
// Tracks pending destination writes per register, stalls on RAW hazards and
// on destination-counter saturation, and drains for a few cycles after flush.
// Optional feature: define ISSUE_SCOREBOARD_PERF_EN to build the saturating
// hazard/back-pressure stall counter on stall_cnt_o (tied to 0 otherwise).
module issue_scoreboard
  import cpu_configuration::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned NREG         = 32,
  parameter int unsigned CNT_W        = 2,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               dec_valid_i,
  output logic               dec_ready_o,
  input  logic [RegAdrW-1:0] rs1_ad_i,
  input  logic [RegAdrW-1:0] rs2_ad_i,
  input  logic [RegAdrW-1:0] rd_ad_i,
  input  logic               rs1_used_i,
  input  logic               rs2_used_i,
  input  logic               rd_used_i,
  output logic               iss_valid_o,
  input  logic               iss_ready_i,
  input  logic               wb_valid_i,
  input  logic [RegAdrW-1:0] wb_adr_i,
  input  logic               flush_i,
  output logic [NREG-1:0]    busy_o,
  output logic               err_o,
  output logic [XLEN-1:0]    stall_cnt_o
);

  sb_state_t         state_q, state_d;
  logic [DrainW-1:0] drain_q, drain_d;
  logic              err_q, err_d;

  logic [NREG-1:0] zero_vec;
  logic [NREG-1:0] max_vec;

  logic run;
  logic hazard;
  logic fire;
  logic wb_ok;

  assign run = (state_q == Run);

  // Hazards use registered counts only; register 0 is never pending.
  assign hazard = (rs1_used_i && (rs1_ad_i != '0) && !zero_vec[rs1_ad_i]) ||
                  (rs2_used_i && (rs2_ad_i != '0) && !zero_vec[rs2_ad_i]) ||
                  (rd_used_i  && (rd_ad_i  != '0) &&  max_vec[rd_ad_i]);

  assign fire        = dec_valid_i && run && !hazard && iss_ready_i && !flush_i;
  assign dec_ready_o = fire;
  assign iss_valid_o = fire;

  // Write-backs only count in RUN; results arriving in the flush cycle or
  // during DRAIN belong to squashed work and are ignored.
  assign wb_ok = wb_valid_i && run && !flush_i && (wb_adr_i != '0);

  assign zero_vec[0] = 1'b1;
  assign max_vec[0]  = 1'b0;

  for (genvar i = 1; i < NREG; i++) begin : g_cnt
    logic inc, dec;
    assign inc = fire && rd_used_i && (rd_ad_i == RegAdrW'(i));
    assign dec = wb_ok && (wb_adr_i == RegAdrW'(i));

    sb_counter #(
      .CntW (CNT_W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .inc_i  (inc),
      .dec_i  (dec),
      .clr_i  (flush_i),
      .max_o  (max_vec[i]),
      .zero_o (zero_vec[i])
    );
  end

  assign busy_o = ~zero_vec;
  assign err_o  = err_q;

  // Controller next state: flush (re)starts the drain window; with a single
  // flush cycle there is no drain state at all.
  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    err_d   = err_q;
    if (flush_i) begin
      state_d = (FLUSH_CYCLES > 1) ? Drain : Run;
      drain_d = DrainW'(FLUSH_CYCLES - 1);
    end else if (state_q == Drain) begin
      if (drain_q <= DrainW'(1)) begin
        state_d = Run;
        drain_d = '0;
      end else begin
        drain_d = drain_q - 1'b1;
      end
    end
    if (wb_ok && zero_vec[wb_adr_i]) begin
      err_d = 1'b1;
    end
  end

  // Controller state, drain counter and sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= Run;
      drain_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      err_q   <= err_d;
    end
  end

`ifdef ISSUE_SCOREBOARD_PERF_EN
  logic [XLEN-1:0] stall_q, stall_d;

  // Count cycles lost to hazards or downstream back-pressure while in RUN.
  always_comb begin
    stall_d = stall_q;
    if (dec_valid_i && run && (hazard || !iss_ready_i) && (stall_q != {XLEN{1'b1}})) begin
      stall_d = stall_q + 1'b1;
    end
  end

  // Stall counter register; cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_scoreboard.sv
// Directed, table-driven bench for issue_scoreboard (default parameters).
module tb_issue_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        dec_valid_i;
  logic        dec_ready_o;
  logic [4:0]  rs1_ad_i, rs2_ad_i, rd_ad_i;
  logic        rs1_used_i, rs2_used_i, rd_used_i;
  logic        iss_valid_o;
  logic        iss_ready_i;
  logic        wb_valid_i;
  logic [4:0]  wb_adr_i;
  logic        flush_i;
  logic [31:0] busy_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  issue_scoreboard u_dut (
    .clk         (clk),
    .rst         (rst),
    .dec_valid_i (dec_valid_i),
    .dec_ready_o (dec_ready_o),
    .rs1_ad_i    (rs1_ad_i),
    .rs2_ad_i    (rs2_ad_i),
    .rd_ad_i     (rd_ad_i),
    .rs1_used_i  (rs1_used_i),
    .rs2_used_i  (rs2_used_i),
    .rd_used_i   (rd_used_i),
    .iss_valid_o (iss_valid_o),
    .iss_ready_i (iss_ready_i),
    .wb_valid_i  (wb_valid_i),
    .wb_adr_i    (wb_adr_i),
    .flush_i     (flush_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .stall_cnt_o (stall_cnt_o)
  );

  typedef struct {
    logic        v;
    logic [4:0]  rs1;
    logic        u1;
    logic [4:0]  rs2;
    logic        u2;
    logic [4:0]  rd;
    logic        ud;
    logic        rdy;
    logic        wbv;
    logic [4:0]  wba;
    logic        fl;
    logic        e_rdy;
    logic [31:0] e_busy;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic ud, input logic rdy, input logic wbv,
                     input logic [4:0] wba, input logic fl, input logic e_rdy,
                     input logic [31:0] e_busy, input logic e_err);
    vec_t r;
    r = '{v, rs1, u1, rs2, u2, rd, ud, rdy, wbv, wba, fl, e_rdy, e_busy, e_err};
    vecs.push_back(r);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t r);
    dec_valid_i = r.v;
    rs1_ad_i    = r.rs1;
    rs1_used_i  = r.u1;
    rs2_ad_i    = r.rs2;
    rs2_used_i  = r.u2;
    rd_ad_i     = r.rd;
    rd_used_i   = r.ud;
    iss_ready_i = r.rdy;
    wb_valid_i  = r.wbv;
    wb_adr_i    = r.wba;
    flush_i     = r.fl;
  endtask

  task automatic idle();
    vec_t r;
    r = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0, 1'b0,
          1'b0, 32'h0, 1'b0};
    drive(r);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    // Columns: v rs1 u1 rs2 u2 rd ud rdy wbv wba fl | rdy busy err
    // Reset state
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 0);
    // RAW stall on r5, released one cycle after write-back
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h20, 0);
    add(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h20, 0);
    add(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h20, 0);
    add(1, 5, 1, 0, 0, 0, 0, 1, 1, 5, 0,  0, 32'h20, 0);
    add(1, 5, 1, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h0, 0);
    // x0 immunity
    add(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0,  1, 32'h0, 0);
    // Downstream not ready
    add(1, 0, 0, 0, 0, 4, 1, 0, 0, 0, 0,  0, 32'h0, 0);
    // Saturation on r7
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 32'h80, 0);
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 32'h80, 0);
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  0, 32'h80, 0);
    add(1, 0, 0, 0, 0, 7, 1, 1, 1, 7, 0,  0, 32'h80, 0);
    add(1, 0, 0, 0, 0, 7, 1, 1, 0, 0, 0,  1, 32'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 7, 0,  0, 32'h80, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 0);
    // Simultaneous inc/dec on r3
    add(1, 0, 0, 0, 0, 3, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 0, 0, 0, 0, 3, 1, 1, 1, 3, 0,  1, 32'h8, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h8, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 0,  0, 32'h8, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 0);
    // rs2 hazard; unused rs1 never stalls
    add(1, 0, 0, 0, 0, 6, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 0, 0, 6, 1, 0, 0, 1, 0, 0, 0,  0, 32'h40, 0);
    add(1, 6, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h40, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 0,  0, 32'h40, 0);
    // Flush with busy = 0x24; write-back during drain is ignored
    add(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0,  1, 32'h0, 0);
    add(1, 0, 0, 0, 0, 5, 1, 1, 0, 0, 0,  1, 32'h4, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 32'h24, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 1, 2, 0,  0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h0, 0);
    // Second flush during drain extends the block
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1,  0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 0);
    add(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 32'h0, 0);
    // Write-back to idle r9 in RUN sets sticky error
    add(0, 0, 0, 0, 0, 0, 0, 1, 1, 9, 0,  0, 32'h0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 32'h0, 1);

    do_reset();
    check("reset_stall_cnt", stall_cnt_o, 32'h0);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      @(negedge clk);
      check($sformatf("row%0d_ready", i), {31'h0, dec_ready_o}, {31'h0, vecs[i].e_rdy});
      check($sformatf("row%0d_iss_valid", i), {31'h0, iss_valid_o}, {31'h0, vecs[i].e_rdy});
      check($sformatf("row%0d_busy", i), busy_o, vecs[i].e_busy);
      check($sformatf("row%0d_err", i), {31'h0, err_o}, {31'h0, vecs[i].e_err});
      @(posedge clk);
      #1;
    end

    // Reset wins over a concurrent fire and flush; clears sticky error.
    dec_valid_i = 1'b1; rd_ad_i = 5'd11; rd_used_i = 1'b1; flush_i = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    idle();
    @(negedge clk);
    check("rst_busy", busy_o, 32'h0);
    check("rst_err", {31'h0, err_o}, 32'h0);
    check("rst_stall_cnt", stall_cnt_o, 32'h0);
    // Reset left state in RUN: a plain instruction issues immediately.
    dec_valid_i = 1'b1;
    @(negedge clk);
    check("rst_run_ready", {31'h0, dec_ready_o}, 32'h1);
    @(posedge clk);

    // Ten hazard-stalled cycles on r10.
    #1;
    rd_ad_i = 5'd10; rd_used_i = 1'b1;
    @(posedge clk);
    #1;
    rd_used_i = 1'b0; rs1_ad_i = 5'd10; rs1_used_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("perf_stall%0d", k), {31'h0, dec_ready_o}, 32'h0);
      @(posedge clk);
      #1;
    end
    idle();
    @(negedge clk);
`ifdef ISSUE_SCOREBOARD_PERF_EN
    check("stall_cnt", stall_cnt_o, 32'd10);
`else
    check("stall_cnt", stall_cnt_o, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/issue_scoreboard.md
# issue_scoreboard

Issue controller sitting between the decode stage and the register-read / register-to-compute pipeline stage. It tracks outstanding destination-register writes with per-register pending counters and blocks issue on read-after-write hazards. It releases registers on result write-back and recovers from pipeline flushes. It produces the issue handshake that gates the register-read stage, replacing its constant `ok` with a real hazard-aware stall.

## Interface
- `XLEN`, 32: data width; used only for the perf counter width.
- `NREG`, 32: architectural registers; register 0 is hard-wired zero and never busy.
- `CNT_W`, 2: pending-counter width; maximum outstanding writes per register is 2^CNT_W − 1.
- `FLUSH_CYCLES`, 2: cycles after a flush during which issue is blocked (1..15).

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `dec_valid_i`  in  1  decoded instruction present.
- `dec_ready_o`  out  1  instruction accepted this cycle (issue fires).
- `rs1_ad_i`, `rs2_ad_i`, `rd_ad_i`  in  5 each  source and destination register addresses.
- `rs1_used_i`, `rs2_used_i`, `rd_used_i`  in  1 each  operand is read / destination is written.
- `iss_valid_o`  out  1  issue to the register-read/pipeline FIFO.
- `iss_ready_i`  in  1  downstream FIFO can accept.
- `wb_valid_i`  in  1  result write-back valid.
- `wb_adr_i`  in  5  write-back register address.
- `flush_i`  in  1  pipeline flush request.
- `busy_o`  out  NREG  per-register `count != 0`.
- `err_o`  out  1  sticky; set on write-back to a register whose count is 0 while in RUN.
- `stall_cnt_o`  out  XLEN  hazard-stall cycle counter (see Configuration).

## Operation
- **State machine**, encoded as `sb_state_t`:
  - RUN: issue allowed.
  - DRAIN: issue blocked; a down-counter loaded with `FLUSH_CYCLES − 1` counts to 0, then the state returns to RUN.
- **Hazard** is computed from registered counts only; there is no same-cycle write-back bypass. Any of the following raises a hazard:
  - `rs1_used_i & count[rs1] != 0`
  - `rs2_used_i & count[rs2] != 0`
  - `rd_used_i & count[rd] == max`
- Address 0 never produces a hazard and is never counted.
- **Issue fire** = `dec_valid_i & state==RUN & !hazard & iss_ready_i`.
  - `dec_ready_o = iss_valid_o = fire`, both combinational.
  - `iss_valid_o` does not depend on `iss_ready_i` being sampled earlier.
- **On fire** with `rd_used_i` and `rd != 0`: `count[rd]++`.
- **On `wb_valid_i`** in RUN with `wb_adr != 0`:
  - If `count > 0`: `count[wb_adr]--`.
  - If `count == 0`: the count is unchanged and `err_o` is set.
- **Increment and decrement on the same register in the same cycle**: net count unchanged.
- **On `flush_i`**:
  - All counts clear to 0 next cycle.
  - State goes to DRAIN and the drain counter reloads.
  - `fire` is forced to 0 in the flush cycle.
  - Write-backs during DRAIN do not change counts and do not set `err_o`. Late results from flushed work are discarded from the count view.
- **Flush during DRAIN**: the drain counter restarts.
- **Reset during any state**: reset wins over flush, fire and write-back.

## Timing
- Reset values:
  - state RUN; all counts 0; `busy_o` 0; `err_o` 0; `stall_cnt_o` 0.
  - `dec_ready_o` / `iss_valid_o` follow the combinational rule (1 only if valid and ready).
- Issue latency: 0 cycles; the accept decision is made in the same cycle as `dec_valid_i`.
- `busy_o` reflects a fire or write-back one cycle after the event.
- A dependent instruction can issue at the earliest 1 cycle after the producer's `wb_valid_i`.
- Flush recovery: the first possible fire is `FLUSH_CYCLES` cycles after the cycle `flush_i` is sampled high.
- When `dec_valid_i` is held with a hazard, inputs must stay stable until `dec_ready_o`.

## Configuration
- `ISSUE_SCOREBOARD_PERF_EN` defined:
  - `stall_cnt_o` increments each cycle with `dec_valid_i & state==RUN & (hazard | !iss_ready_i)`.
  - It saturates at all-ones and clears only on reset.
- Not defined: `stall_cnt_o` is tied to 0 and no counter register is instantiated.

## Structure
- Shared package `cpu_configuration` holds:
  - `sb_state_t` (RUN, DRAIN)
  - the register-address width constant (5)
  - `NREG`
- Sub-module `sb_counter` holds one saturating up/down counter per register with `inc`, `dec`, `clr` and `max`/`zero` flags. It is instantiated NREG−1 times via generate; register 0 is constant zero.

## Test plan
- **RAW stall:** fire `rd=5` at cycle 0; at cycle 1 present `rs1=5` → `dec_ready_o=0`. Pulse `wb_valid_i`, `wb_adr=5` at cycle 4 → `dec_ready_o=1` at cycle 5; `busy_o[5]` falls at cycle 5.
- **x0 immunity:** fire `rd=0`, then `rs1=0`/`rs2=0` → no stall; `busy_o[0]` stays 0.
- **Saturation:** with `CNT_W=2`, fire 3 writes to `rd=7` → a 4th writer to `rd=7` stalls. One write-back → the 4th fires the next cycle.
- **Simultaneous events:** `count[3]=1`; fire `rd=3` and `wb_adr=3` in the same cycle → `count[3]` stays 1 and `busy_o[3]=1`.
- **Flush:**
  - With `busy_o = 0x0000_0024`, assert `flush_i` → next cycle `busy_o=0` and issue is blocked for 2 cycles.
  - `wb_adr=2` during DRAIN → `err_o` stays 0.
  - A second flush in DRAIN extends the block.
- **Error/perf:** write-back to an idle register 9 in RUN → `err_o=1` sticky until reset. With the macro defined, 10 stalled cycles → `stall_cnt_o=10`.
